// File: rtl/waterfall_seq_ctrl.sv
// waterfall_seq_ctrl
// Step sequencer for a universal shift register driving an LED chain.
// A prescaler divides clk down to one step tick every DIV clocks; on each
// tick the FSM performs one action (clear, parallel load, shift right or
// shift left) by pulsing the register's S1/S0/CR/D/DSR/DSL pins for exactly
// one clock. Between ticks the register is held (S1S0=00, CR=1).
//
// Optional feature macro: WATERFALL_FILL_EN
//   defined   : mode_sel=01 selects fill/empty (WIDTH shifts with DSR=1,
//               then WIDTH shifts with DSR=0, repeating).
//   undefined : FILL/EMPTY states do not exist; mode_sel=01 acts as bounce.
module waterfall_seq_ctrl #(
  parameter int WIDTH = 8,  // register width and steps per sweep (>= 2)
  parameter int DIV   = 4   // clocks per step tick (>= 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stop_n,
  input  logic [1:0]       mode_sel,
  input  logic [WIDTH-1:0] pattern,
  output logic             S1,
  output logic             S0,
  output logic             CR,
  output logic [WIDTH-1:0] D,
  output logic             DSR,
  output logic             DSL,
  output logic             tick,
  output logic [2:0]       state
);

  // Prescaler needs at least one bit even when DIV=1 (it then stays at 0).
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [PW-1:0] PRESC_MAX     = PW'(DIV - 1);
  // A bounce/wrap sweep is WIDTH-1 shifts: counts 0 .. WIDTH-2.
  localparam logic [CW-1:0] CNT_LAST_SH   = CW'(WIDTH - 2);
  // A fill/empty phase is WIDTH shifts: counts 0 .. WIDTH-1.
  localparam logic [CW-1:0] CNT_LAST_FILL = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHR   = 3'd2,
    ST_SHL   = 3'd3
`ifdef WATERFALL_FILL_EN
    ,
    ST_FILL  = 3'd4,
    ST_EMPTY = 3'd5
`endif
  } state_e;

  // Run mode latched at LOAD so mode_sel changes only act at the next LOAD.
  typedef enum logic [1:0] {
    M_BOUNCE = 2'd0,
    M_WRAP   = 2'd1,
    M_FILL   = 2'd2
  } run_mode_e;

  // Map the mode_sel pins onto a run mode; 11 (and 01 without the fill
  // feature) fall back to bounce.
  function automatic run_mode_e decode_mode(input logic [1:0] sel);
    run_mode_e m;
    case (sel)
      2'b10:   m = M_WRAP;
`ifdef WATERFALL_FILL_EN
      2'b01:   m = M_FILL;
`endif
      default: m = M_BOUNCE;
    endcase
    return m;
  endfunction

  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  state_e           state_q, state_d;
  run_mode_e        mode_q,  mode_d;
  logic             s1_q,  s1_d;
  logic             s0_q,  s0_d;
  logic             cr_q,  cr_d;
  logic [WIDTH-1:0] d_q,   d_d;
  logic             dsr_q, dsr_d;
  logic             dsl_q, dsl_d;
  logic             tick_q, tick_d;

  logic             step;
  run_mode_e        mode_sel_dec;

  // A step fires on the last prescaler count, only while running; stop_n=0
  // in that same cycle therefore suppresses the tick.
  assign step         = stop_n && (presc_q == PRESC_MAX);
  assign mode_sel_dec = decode_mode(mode_sel);

  // Prescaler: counts 0..DIV-1 while running, holds its exact value on pause.
  always_comb begin
    presc_d = presc_q;
    if (stop_n) begin
      presc_d = step ? '0 : presc_q + PW'(1);
    end
  end

  // FSM next state and registered pin values for the coming clock.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    s1_d    = 1'b0;
    s0_d    = 1'b0;
    cr_d    = 1'b1;
    d_d     = d_q;
    dsr_d   = 1'b0;
    dsl_d   = 1'b0;
    tick_d  = step;

    if (step) begin
      case (state_q)
        ST_CLEAR: begin
          cr_d    = 1'b0;
          state_d = ST_LOAD;
        end

        ST_LOAD: begin
          s1_d   = 1'b1;
          s0_d   = 1'b1;
          d_d    = pattern;
          mode_d = mode_sel_dec;
          cnt_d  = '0;
`ifdef WATERFALL_FILL_EN
          state_d = (mode_sel_dec == M_FILL) ? ST_FILL : ST_SHR;
`else
          state_d = ST_SHR;
`endif
        end

        ST_SHR: begin
          s0_d  = 1'b1;
          dsr_d = 1'b0;
          if (cnt_q == CNT_LAST_SH) begin
            cnt_d   = '0;
            state_d = (mode_q == M_WRAP) ? ST_LOAD : ST_SHL;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_SHL: begin
          s1_d  = 1'b1;
          dsl_d = 1'b0;
          if (cnt_q == CNT_LAST_SH) begin
            cnt_d   = '0;
            state_d = ST_SHR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

`ifdef WATERFALL_FILL_EN
        ST_FILL: begin
          s0_d  = 1'b1;
          dsr_d = 1'b1;
          if (cnt_q == CNT_LAST_FILL) begin
            cnt_d   = '0;
            state_d = ST_EMPTY;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        ST_EMPTY: begin
          s0_d  = 1'b1;
          dsr_d = 1'b0;
          if (cnt_q == CNT_LAST_FILL) begin
            // Re-sample the mode on the way back to FILL; any other mode
            // goes through LOAD so it starts from a fresh seed.
            cnt_d   = '0;
            mode_d  = mode_sel_dec;
            state_d = (mode_sel_dec == M_FILL) ? ST_FILL : ST_LOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif

        default: begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end
      endcase
    end
  end

  // State, counters and all output pins are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
      state_q <= ST_CLEAR;
      mode_q  <= M_BOUNCE;
      s1_q    <= 1'b0;
      s0_q    <= 1'b0;
      cr_q    <= 1'b0;
      d_q     <= '0;
      dsr_q   <= 1'b0;
      dsl_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      s1_q    <= s1_d;
      s0_q    <= s0_d;
      cr_q    <= cr_d;
      d_q     <= d_d;
      dsr_q   <= dsr_d;
      dsl_q   <= dsl_d;
      tick_q  <= tick_d;
    end
  end

  assign S1    = s1_q;
  assign S0    = s0_q;
  assign CR    = cr_q;
  assign D     = d_q;
  assign DSR   = dsr_q;
  assign DSL   = dsl_q;
  assign tick  = tick_q;
  assign state = state_q;

endmodule

// File: doc/waterfall_seq_ctrl.md
# waterfall_seq_ctrl

Step sequencer for the 8-bit waterfall LED chain. It divides `clk` down to a step tick and drives the universal shift register's mode pins (S1/S0), active-low clear (CR), parallel data (D) and serial inputs (DSR/DSL). The register then produces a bounce or wrap light pattern without any manual pin toggling. It sits between the system clock/reset and the shift register, replacing the hand-driven S1/S0/CR/D stimulus.

## Interface
- `WIDTH`, 8: shift-register width; also the step count per sweep (≥2).
- `DIV`, 4: clocks per step tick (≥1).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stop_n` in 1: 0 = pause (prescaler frozen, no steps); 1 = run.
- `mode_sel` in 2: 00 bounce, 01 fill/empty (see Configuration), 10 one-way wrap, 11 treated as 00.
- `pattern` in WIDTH: seed loaded into the register at each LOAD.
- `S1`, `S0` out 1 each: register mode. 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `CR` out 1: active-low register clear.
- `D` out WIDTH: parallel load data.
- `DSR`, `DSL` out 1 each: serial inputs for right and left shifts.
- `tick` out 1: one-clock pulse per step.
- `state` out 3: current FSM state encoding, for debug.

## Operation
- Prescaler `presc` counts 0..DIV-1 while `stop_n`=1.
- At `presc`==DIV-1 it wraps to 0 and the FSM takes one step.
- All outputs are registered. A step's action is visible for exactly one clock, coincident with `tick`=1.
- In every non-tick cycle: S1S0=00, CR=1, `tick`=0.
- Step counter `cnt` is clog2(WIDTH) bits wide.
- FSM states and the action each state performs on a tick:
  - CLEAR: CR=0 → go to LOAD.
  - LOAD: S1S0=11, D=`pattern`; `mode_sel` is sampled here; `cnt`=0 → go to SHR (or FILL).
  - SHR: S1S0=01, DSR=0, `cnt`++. When `cnt` reaches WIDTH-1 shifts, go to SHL (bounce) or LOAD (wrap), and clear `cnt`.
  - SHL: S1S0=10, DSL=0, `cnt`++. After WIDTH-1 shifts, go to SHR and clear `cnt`.
  - FILL / EMPTY: present only with the Configuration macro.
- `mode_sel` and `pattern` changes take effect only at the next LOAD.
- `stop_n`=0:
  - `presc`, `cnt` and the FSM state hold.
  - No ticks are generated; outputs stay idle (00, CR=1).
  - Resume continues from the exact held `presc` value.
- `pattern`=0 is loaded as-is; no substitution.

## Timing
- Reset values (asynchronous): S1=S0=0, CR=0, D=0, DSR=DSL=0, `tick`=0, `presc`=0, `cnt`=0, state=CLEAR.
- Clock edge 1 after `rst_n` release: CR returns to 1.
- First tick (CLEAR, CR=0) is visible after clock edge DIV following `rst_n` release.
- LOAD is visible after edge 2·DIV; the first shift after edge 3·DIV.
- With DIV=1, a tick occurs every clock and actions occur on consecutive cycles.
- A `stop_n` falling edge in the same cycle that `presc`==DIV-1 suppresses that tick.
- Asserting `rst_n` mid-sweep forces reset values immediately, with no clock needed. The sequence restarts from CLEAR.

## Configuration
- `WATERFALL_FILL_EN` defined: `mode_sel`=01 enables two extra states.
  - From LOAD, go to FILL.
  - FILL: WIDTH ticks of S1S0=01 with DSR=1.
  - Then EMPTY: WIDTH ticks of S1S0=01 with DSR=0.
  - Then back to FILL; `mode_sel` is re-sampled on the FILL entry that follows EMPTY.
- `WATERFALL_FILL_EN` undefined: FILL and EMPTY are absent; `mode_sel`=01 behaves as 00 (bounce).

## Test plan
All scenarios use DIV=4, WIDTH=8, `pattern`=8'h80 unless stated.
- Reset release with `stop_n`=1, mode 00:
  - CR=0 for one clock after edge 4; S1S0=11 with D=8'h80 after edge 8; S1S0=01 after edge 12.
  - S1S0=00 in every other cycle.
- Bounce, mode 00: exactly 7 SHR pulses, then 7 SHL pulses, then SHR again. A behavioural shift-register model must return to 8'h80 after 14 shifts.
- Pause: `stop_n`=0 for 10 clocks after the 3rd SHR pulse.
  - No pulses during the pause; `presc` and `cnt` frozen.
  - After resume, exactly 4 more SHR pulses before the first SHL.
- Wrap, mode 10: after 7 SHR pulses, LOAD with D=`pattern` (change `pattern` to 8'h81 mid-sweep → D=8'h81 at that LOAD), then 7 SHR again; no SHL ever.
- Asynchronous reset mid-SHL: outputs go to reset values in the same cycle; the next CR=0 pulse occurs DIV edges after release.
- With `WATERFALL_FILL_EN`, mode 01: 8 SHR pulses with DSR=1, then 8 with DSR=0, repeating. Without the macro, mode 01 matches the mode 00 pulse trace.
